// File: rtl/fp_writeback.sv
// FP register-file writeback arbiter: merges a one-entry load holding register and an
// in-order FPU result queue into one registered write per cycle. FP_WB_BYPASS_EN enables FPU queue bypass.
module fp_writeback #(
  parameter int unsigned FLEN       = 32,
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [FLEN-1:0]            ld_data,
  input  logic                       fpu_valid,
  output logic                       fpu_ready,
  input  logic [4:0]                 fpu_rd,
  input  logic [FLEN-1:0]            fpu_data,
  output logic                       Reg_Wr,
  output logic [4:0]                 Rd_Wr,
  output logic [FLEN-1:0]            Rd_In,
  output logic [$clog2(QDEPTH):0]    q_count
);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic            ld_full;
  logic [4:0]      ld_rd_q;
  logic [FLEN-1:0] ld_data_q;
  logic [4:0]      q_rd   [QDEPTH];
  logic [FLEN-1:0] q_data [QDEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [3:0]      starve_cnt;

  logic            q_nonempty;
  logic            q_full;
  logic            bypass;
  logic            grant_q;
  logic            grant_fpu;
  logic            grant_ld;
  logic            push_ld;
  logic            push_q;
  logic [4:0]      win_rd;
  logic [FLEN-1:0] win_data;

  assign q_nonempty = (q_count != '0);
  assign q_full     = (q_count == CW'(QDEPTH));

`ifdef FP_WB_BYPASS_EN
  assign bypass = !q_nonempty && fpu_valid && !ld_full && !flush;
`else
  assign bypass = 1'b0;
`endif

  // Queue-head grant never depends on same-cycle valids; bypass only happens with both buffers empty.
  assign grant_q   = !flush && q_nonempty && (!ld_full || (starve_cnt == 4'(STARVE_MAX)));
  assign grant_fpu = grant_q || bypass;
  assign grant_ld  = !flush && ld_full && !grant_q;

  assign ld_ready  = !ld_full || grant_ld;
  assign fpu_ready = !q_full || grant_q;

  assign push_ld = ld_valid && ld_ready && !flush;
  assign push_q  = fpu_valid && fpu_ready && !flush && !bypass;

  always_comb begin
    win_rd   = ld_rd_q;
    win_data = ld_data_q;
    if (grant_q) begin
      win_rd   = q_rd[rd_ptr];
      win_data = q_data[rd_ptr];
    end else if (bypass) begin
      win_rd   = fpu_rd;
      win_data = fpu_data;
    end
  end

  // FPU queue storage; occupancy and pointers carry the reset.
  always_ff @(posedge CLK) begin
    if (push_q) begin
      q_rd[wr_ptr]   <= fpu_rd;
      q_data[wr_ptr] <= fpu_data;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ld_full    <= 1'b0;
      ld_rd_q    <= '0;
      ld_data_q  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_count    <= '0;
      starve_cnt <= '0;
      Reg_Wr     <= 1'b0;
      Rd_Wr      <= '0;
      Rd_In      <= '0;
    end else if (flush) begin
      ld_full    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_count    <= '0;
      starve_cnt <= '0;
      Reg_Wr     <= 1'b0;
    end else begin
      if (grant_ld) ld_full <= 1'b0;
      if (push_ld) begin
        ld_full   <= 1'b1;
        ld_rd_q   <= ld_rd;
        ld_data_q <= ld_data;
      end
      if (push_q)  wr_ptr <= wr_ptr + PW'(1);
      if (grant_q) rd_ptr <= rd_ptr + PW'(1);
      case ({push_q, grant_q})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
      // Counts load wins that overtake a waiting FPU head.
      if (grant_fpu || !q_nonempty) starve_cnt <= '0;
      else if (grant_ld && (starve_cnt != 4'(STARVE_MAX))) starve_cnt <= starve_cnt + 4'd1;
      Reg_Wr <= grant_ld || grant_fpu;
      if (grant_ld || grant_fpu) begin
        Rd_Wr <= win_rd;
        Rd_In <= win_data;
      end
    end
  end
endmodule

// File: tb/tb_fp_writeback.sv
// Self-checking bench for fp_writeback: directed scenarios plus randomized traffic against a queue-based model.
module tb_fp_writeback;
  localparam int unsigned FLEN       = 32;
  localparam int unsigned QDEPTH     = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned CW         = $clog2(QDEPTH) + 1;
`ifdef FP_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [FLEN-1:0] ld_data;
  logic            fpu_valid;
  logic            fpu_ready;
  logic [4:0]      fpu_rd;
  logic [FLEN-1:0] fpu_data;
  logic            Reg_Wr;
  logic [4:0]      Rd_Wr;
  logic [FLEN-1:0] Rd_In;
  logic [CW-1:0]   q_count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fp_writeback #(.FLEN(FLEN), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .rst_n(rst_n), .flush(flush),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
    .Reg_Wr(Reg_Wr), .Rd_Wr(Rd_Wr), .Rd_In(Rd_In), .q_count(q_count)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [FLEN-1:0] data;
  } ent_t;

  // Reference model state
  ent_t            m_q[$];
  bit              m_ld_full;
  ent_t            m_ld;
  int              m_starve;
  bit              exp_wr;
  logic [4:0]      exp_rd;
  logic [FLEN-1:0] exp_data;
  bit              exp_ld_ready;
  bit              exp_fpu_ready;
  // DUT observations taken in the cycle before the edge
  bit              obs_ld_ready;
  bit              obs_fpu_ready;
  int              obs_q_pre;
  ent_t            wr_log[$];
  logic [FLEN-1:0] rf_dut   [32];
  logic [FLEN-1:0] rf_model [32];

  task automatic idle();
    flush = 1'b0; ld_valid = 1'b0; fpu_valid = 1'b0;
    ld_rd = '0; ld_data = '0; fpu_rd = '0; fpu_data = '0;
  endtask

  task automatic model_reset();
    m_q.delete(); m_ld_full = 1'b0; m_starve = 0;
    exp_wr = 1'b0; exp_rd = '0; exp_data = '0;
  endtask

  // One clock cycle: sample readies, step the model over the edge, log the DUT write.
  task automatic tick();
    bit byp, gq, gl;
    ent_t e;
    #1;
    obs_ld_ready  = ld_ready;
    obs_fpu_ready = fpu_ready;
    obs_q_pre     = int'(q_count);
    byp = BYP && (m_q.size() == 0) && fpu_valid && !m_ld_full && !flush;
    gq  = !flush && (m_q.size() > 0) && (!m_ld_full || m_starve == int'(STARVE_MAX));
    gl  = !flush && m_ld_full && !gq;
    exp_ld_ready  = !m_ld_full || gl;
    exp_fpu_ready = (m_q.size() < int'(QDEPTH)) || gq;
    @(posedge CLK);
    if (flush || gq || byp || m_q.size() == 0) m_starve = 0;
    else if (gl && m_starve < int'(STARVE_MAX)) m_starve++;
    exp_wr = gq || byp || gl;
    e = '{rd: exp_rd, data: exp_data};
    if (gq) e = m_q.pop_front();
    else if (byp) e = '{rd: fpu_rd, data: fpu_data};
    else if (gl) begin e = m_ld; m_ld_full = 1'b0; end
    if (exp_wr) begin
      exp_rd = e.rd; exp_data = e.data;
      if (e.rd != 5'd0) rf_model[e.rd] = e.data;
    end
    if (flush) begin
      m_ld_full = 1'b0; m_q.delete();
    end else begin
      if (ld_valid && exp_ld_ready) begin m_ld_full = 1'b1; m_ld = '{rd: ld_rd, data: ld_data}; end
      if (fpu_valid && exp_fpu_ready && !byp) m_q.push_back('{rd: fpu_rd, data: fpu_data});
    end
    #1;
    if (Reg_Wr) begin
      wr_log.push_back('{rd: Rd_Wr, data: Rd_In});
      if (Rd_Wr != 5'd0) rf_dut[Rd_Wr] = Rd_In;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); model_reset();
    #3;
    checks++; if (Reg_Wr !== 1'b0)    begin errors++; $display("FAIL reset_reg_wr got %b want 0", Reg_Wr); end
    checks++; if (Rd_Wr !== 5'd0)     begin errors++; $display("FAIL reset_rd_wr got %0d want 0", Rd_Wr); end
    checks++; if (Rd_In !== '0)       begin errors++; $display("FAIL reset_rd_in got %h want 0", Rd_In); end
    checks++; if (q_count !== '0)     begin errors++; $display("FAIL reset_q_count got %0d want 0", q_count); end
    checks++; if (ld_ready !== 1'b1)  begin errors++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
    checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL reset_fpu_ready got %b want 1", fpu_ready); end
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_fpu();
    int lat;
    bit found;
    int exp_lat;
    exp_lat = BYP ? 1 : 2;
    idle(); fpu_valid = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h3F80_0000;
    tick();
    checks++; if (obs_fpu_ready !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", obs_fpu_ready); end
    idle();
    lat = 1; found = 1'b0;
    while (!found && lat < 10) begin
      if (Reg_Wr) found = 1'b1;
      else begin tick(); lat++; end
    end
    checks++; if (!found)            begin errors++; $display("FAIL single_timeout no write within %0d cycles", lat); end
    checks++; if (lat != exp_lat)    begin errors++; $display("FAIL single_latency got %0d want %0d", lat, exp_lat); end
    checks++; if (Rd_Wr !== 5'd5)    begin errors++; $display("FAIL single_rd got %0d want 5", Rd_Wr); end
    checks++; if (Rd_In !== 32'h3F80_0000) begin errors++; $display("FAIL single_data got %h want 3f800000", Rd_In); end
    tick();
    checks++; if (Reg_Wr !== 1'b0)   begin errors++; $display("FAIL single_one_pulse got %b want 0", Reg_Wr); end
    checks++; if (q_count !== '0)    begin errors++; $display("FAIL single_q_empty got %0d want 0", q_count); end
  endtask

  task automatic test_starvation();
    logic [4:0]      erd [8];
    logic [FLEN-1:0] edat [8];
    int fpu_writes;
    erd  = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd7, 5'd1, 5'd1};
    edat = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104, 32'h777, 32'd105, 32'd106};
    wr_log.delete(); idle();
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'd100;
    for (int c = 0; c < 12; c++) begin
      fpu_valid = (c == 1); fpu_rd = 5'd7; fpu_data = 32'h777;
      tick();
      if (obs_ld_ready) ld_data = ld_data + 32'd1;
    end
    idle(); repeat (3) tick();
    checks++; if (wr_log.size() < 8) begin errors++; $display("FAIL starve_count got %0d writes want >=8", wr_log.size()); end
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i].rd !== erd[i] || wr_log[i].data !== edat[i]) begin
        errors++; $display("FAIL starve_order[%0d] got rd %0d data %h want rd %0d data %h",
                           i, wr_log[i].rd, wr_log[i].data, erd[i], edat[i]);
      end
    end
    fpu_writes = 0;
    foreach (wr_log[i]) if (wr_log[i].rd == 5'd7) fpu_writes++;
    checks++; if (fpu_writes != 1) begin errors++; $display("FAIL starve_fpu_once got %0d want 1", fpu_writes); end
  endtask

  task automatic test_queue_full();
    int k;
    bit saw_full;
    int nf;
    logic [FLEN-1:0] next_ld;
    wr_log.delete(); idle();
    k = 0; saw_full = 1'b0; ld_rd = 5'd1; ld_data = 32'd200;
    for (int c = 0; c < 30; c++) begin
      ld_valid  = (c < 20);
      fpu_valid = (c >= 1) && (k < 3);
      fpu_rd    = 5'(10 + k);
      fpu_data  = 32'hF0 + 32'(k);
      tick();
      if (fpu_valid && obs_fpu_ready) k++;
      if (ld_valid && obs_ld_ready) ld_data = ld_data + 32'd1;
      checks++;
      if (obs_fpu_ready !== exp_fpu_ready) begin
        errors++; $display("FAIL qfull_fpu_ready cyc %0d got %b want %b", c, obs_fpu_ready, exp_fpu_ready);
      end
      if (!obs_fpu_ready) begin
        saw_full = 1'b1;
        checks++;
        if (obs_q_pre != int'(QDEPTH)) begin errors++; $display("FAIL qfull_not_full cyc %0d q_count %0d want %0d", c, obs_q_pre, QDEPTH); end
      end
    end
    idle(); repeat (3) tick();
    checks++; if (!saw_full) begin errors++; $display("FAIL qfull_never_full got ready always 1 want a stall"); end
    nf = 0; next_ld = 32'd200;
    foreach (wr_log[i]) begin
      if (wr_log[i].rd >= 5'd10) begin
        checks++;
        if (wr_log[i].rd !== 5'(10 + nf) || wr_log[i].data !== 32'hF0 + 32'(nf)) begin
          errors++; $display("FAIL qfull_fpu_order[%0d] got rd %0d want %0d", nf, wr_log[i].rd, 10 + nf);
        end
        nf++;
      end else begin
        checks++;
        if (wr_log[i].data !== next_ld) begin errors++; $display("FAIL qfull_ld_order got %0d want %0d", wr_log[i].data, next_ld); end
        next_ld = next_ld + 32'd1;
      end
    end
    checks++; if (nf != 3) begin errors++; $display("FAIL qfull_fpu_count got %0d want 3", nf); end
    checks++; if (q_count !== '0) begin errors++; $display("FAIL qfull_drained got %0d want 0", q_count); end
  endtask

  task automatic test_flush();
    wr_log.delete(); idle();
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'hA0;
    tick();
    ld_rd = 5'd3; ld_data = 32'hB0; fpu_valid = 1'b1; fpu_rd = 5'd8; fpu_data = 32'h80;
    tick();
    ld_rd = 5'd4; ld_data = 32'hC0; fpu_rd = 5'd9; fpu_data = 32'h90;
    tick();
    checks++; if (q_count !== CW'(2)) begin errors++; $display("FAIL flush_setup_q got %0d want 2", q_count); end
    checks++; if (Reg_Wr !== 1'b1 || Rd_Wr !== 5'd3) begin errors++; $display("FAIL flush_pending got wr %b rd %0d want 1/3", Reg_Wr, Rd_Wr); end
    flush = 1'b1; ld_rd = 5'd5; ld_data = 32'hD0; fpu_rd = 5'd12; fpu_data = 32'hC;
    tick();
    checks++; if (Reg_Wr !== 1'b0)    begin errors++; $display("FAIL flush_reg_wr got %b want 0", Reg_Wr); end
    checks++; if (q_count !== '0)     begin errors++; $display("FAIL flush_q_count got %0d want 0", q_count); end
    checks++; if (ld_ready !== 1'b1)  begin errors++; $display("FAIL flush_ld_ready got %b want 1", ld_ready); end
    checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL flush_fpu_ready got %b want 1", fpu_ready); end
    idle();
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (Reg_Wr !== 1'b0) begin errors++; $display("FAIL flush_quiet cyc %0d got Reg_Wr %b want 0", c, Reg_Wr); end
    end
    checks++;
    if (wr_log.size() != 2 || wr_log[0].rd !== 5'd2 || wr_log[1].rd !== 5'd3) begin
      errors++; $display("FAIL flush_writes got %0d writes want 2 (rd 2,3)", wr_log.size());
    end
  endtask

  task automatic test_rd_zero();
    wr_log.delete(); idle();
    fpu_valid = 1'b1; fpu_rd = 5'd0; fpu_data = 32'hDEAD_BEEF;
    tick();
    fpu_rd = 5'd6; fpu_data = 32'h1234_5678;
    tick();
    idle(); repeat (5) tick();
    checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL rd0_count got %0d want 2", wr_log.size()); end
    if (wr_log.size() == 2) begin
      checks++; if (wr_log[0].rd !== 5'd0 || wr_log[0].data !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL rd0_write got rd %0d data %h want 0/deadbeef", wr_log[0].rd, wr_log[0].data); end
      checks++; if (wr_log[1].rd !== 5'd6 || wr_log[1].data !== 32'h1234_5678) begin
        errors++; $display("FAIL rd0_next got rd %0d data %h want 6/12345678", wr_log[1].rd, wr_log[1].data); end
    end
    checks++; if (q_count !== '0) begin errors++; $display("FAIL rd0_q_empty got %0d want 0", q_count); end
  endtask

  task automatic test_mid_reset();
    idle();
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h1;
    tick();
    fpu_valid = 1'b1; fpu_rd = 5'd20; fpu_data = 32'h20; ld_data = 32'h2;
    tick();
    fpu_rd = 5'd21; fpu_data = 32'h21; ld_data = 32'h3;
    tick();
    checks++; if (q_count !== CW'(2)) begin errors++; $display("FAIL rst_setup_q got %0d want 2", q_count); end
    #2 rst_n = 1'b0; idle(); model_reset();
    #1;
    checks++; if (Reg_Wr !== 1'b0)    begin errors++; $display("FAIL rst_mid_reg_wr got %b want 0", Reg_Wr); end
    checks++; if (q_count !== '0)     begin errors++; $display("FAIL rst_mid_q_count got %0d want 0", q_count); end
    checks++; if (ld_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_ld_ready got %b want 1", ld_ready); end
    checks++; if (fpu_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_fpu_ready got %b want 1", fpu_ready); end
    @(posedge CLK);
    #1 rst_n = 1'b1;
    wr_log.delete();
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (Reg_Wr !== 1'b0) begin errors++; $display("FAIL rst_quiet cyc %0d got Reg_Wr %b want 0", c, Reg_Wr); end
    end
  endtask

  task automatic test_random();
    foreach (rf_dut[i]) begin rf_dut[i] = '0; rf_model[i] = '0; end
    for (int c = 0; c < 1500; c++) begin
      flush     = ($urandom_range(0, 99) < 3);
      ld_valid  = ($urandom_range(0, 99) < 55);
      fpu_valid = ($urandom_range(0, 99) < 45);
      ld_rd     = 5'($urandom_range(0, 31));
      fpu_rd    = 5'($urandom_range(0, 31));
      ld_data   = $urandom;
      fpu_data  = $urandom;
      tick();
      checks++; if (obs_ld_ready !== exp_ld_ready)   begin errors++; $display("FAIL rand_ld_ready cyc %0d got %b want %b", c, obs_ld_ready, exp_ld_ready); end
      checks++; if (obs_fpu_ready !== exp_fpu_ready) begin errors++; $display("FAIL rand_fpu_ready cyc %0d got %b want %b", c, obs_fpu_ready, exp_fpu_ready); end
      checks++; if (Reg_Wr !== exp_wr)   begin errors++; $display("FAIL rand_reg_wr cyc %0d got %b want %b", c, Reg_Wr, exp_wr); end
      checks++; if (Rd_Wr !== exp_rd)    begin errors++; $display("FAIL rand_rd_wr cyc %0d got %0d want %0d", c, Rd_Wr, exp_rd); end
      checks++; if (Rd_In !== exp_data)  begin errors++; $display("FAIL rand_rd_in cyc %0d got %h want %h", c, Rd_In, exp_data); end
      checks++; if (int'(q_count) != m_q.size()) begin errors++; $display("FAIL rand_q_count cyc %0d got %0d want %0d", c, q_count, m_q.size()); end
    end
    idle(); repeat (8) tick();
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (rf_dut[r] !== rf_model[r]) begin errors++; $display("FAIL rand_regfile x%0d got %h want %h", r, rf_dut[r], rf_model[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_fpu();
    test_starvation();
    test_queue_full();
    test_flush();
    test_rd_zero();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_writeback.md
# fp_writeback

Floating-point writeback arbiter that drives the single write port of the 32-entry FP register file. It merges two producers, the load unit and the multi-cycle FPU, into at most one register write per cycle. FPU results are buffered in a small in-order queue and load results in a one-entry holding register. A starvation counter guarantees FPU forward progress under sustained load traffic.

## Interface
- FLEN, 32: data width of a register write.
- QDEPTH, 2: FPU result queue depth; power of two, ≥2.
- STARVE_MAX, 4: consecutive load grants tolerated while the FPU queue is non-empty; range 1–15.
- CLK  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of all buffered results.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load result accepted when ld_valid && ld_ready.
- ld_rd  in  5  load destination register.
- ld_data  in  FLEN  load result.
- fpu_valid  in  1  FPU result valid.
- fpu_ready  out  1  FPU result accepted when fpu_valid && fpu_ready.
- fpu_rd  in  5  FPU destination register.
- fpu_data  in  FLEN  FPU result.
- Reg_Wr  out  1  registered write enable to the register file.
- Rd_Wr  out  5  registered write address.
- Rd_In  out  FLEN  registered write data.
- q_count  out  clog2(QDEPTH)+1  FPU queue occupancy.

## Operation
- Load holding register: one entry. ld_ready = empty, or occupied and granted this cycle.
- FPU queue: circular FIFO with wrap-around pointers. fpu_ready = (q_count < QDEPTH), or the queue is full and the head is granted this cycle. Simultaneous push and pop when full is legal, and q_count stays at QDEPTH.
- Arbitration is evaluated each cycle over the load entry and the FPU queue head:
  - If only one source is present, it wins.
  - If both are present and starve_cnt == STARVE_MAX, the FPU wins.
  - Otherwise the load wins.
- Starve counter, 4 bits:
  - Increments when the load wins while the FPU queue is non-empty.
  - Clears when the FPU wins or the queue is empty.
  - Saturates at STARVE_MAX.
- The granted entry is popped and loaded into Rd_Wr/Rd_In. Reg_Wr = 1 for one cycle.
- With no grant, Reg_Wr = 0 and Rd_Wr/Rd_In hold their previous values.
- Destination 0 is a real destination. The register file ignores writes to address 0, so such entries are granted and popped and produce Reg_Wr = 1 with Rd_Wr = 0. Benches expect no state change in register 0.
- Each source is strictly in order. No ordering is enforced between sources; the issue stage guarantees no same-rd overlap.
- flush:
  - Empties the load register and the FPU queue and clears starve_cnt.
  - Inputs presented in the flush cycle are dropped.
  - No grant is made in the flush cycle, so Reg_Wr = 0 on the next cycle.
  - A write already in the output register at the flush edge still commits.

## Timing
- Reset values: Reg_Wr = 0, Rd_Wr = 0, Rd_In = 0, q_count = 0, ld_ready = 1, fpu_ready = 1. Buffers are empty and starve_cnt = 0.
- Reset mid-operation discards all buffered results immediately and asynchronously.
- Latency, input accepted at edge N with no contention: entry visible to the arbiter in cycle N+1, Reg_Wr high in cycle N+2, register file updated at edge N+2.
- Throughput: one write per cycle sustained.
- ready outputs are combinational from buffer state and the current grant. They never depend on the same-cycle valid.

## Configuration
- FP_WB_BYPASS_EN defined, FPU path only:
  - If the FPU queue is empty, fpu_valid is high, and no load entry is present, the incoming result bypasses the queue.
  - It is granted in the same cycle and appears with Reg_Wr = 1 in cycle N+1.
  - The load path is unchanged.
- FP_WB_BYPASS_EN undefined: all FPU results go through the queue, with 2-cycle latency.

## Test plan
- Reset: rst_n low mid-burst with 2 FPU entries queued → Reg_Wr = 0, q_count = 0, both readies = 1. No writes appear after release.
- Single FPU result fpu_rd = 5, fpu_data = 0x3F800000 → Reg_Wr = 1, Rd_Wr = 5, Rd_In = 0x3F800000. It appears 2 cycles after acceptance, or 1 cycle with FP_WB_BYPASS_EN.
- Starvation, STARVE_MAX = 4: loads back-to-back to rd = 1 while FPU rd = 7 is queued → four load writes, then the rd = 7 write, then loads resume.
- Queue full, QDEPTH = 2: three FPU results with a continuous load stream → fpu_ready = 0 only while q_count = 2 with no FPU grant. All three rd values are written in order.
- flush with the load register and 2 queued FPU entries → the pending output write commits, Reg_Wr = 0 the next cycle, q_count = 0, nothing further is written.
- rd = 0: FPU result to register 0 → Reg_Wr = 1, Rd_Wr = 0. A later read shows register 0 = 0, and the queue pops normally.
